// File: rtl/zone_sum_acc.sv
// ============================================================================
// Module   : zone_sum_acc
// Purpose  : Per-zone, per-colour saturating frame sums over a raster stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module zone_sum_acc #(
   parameter int ZONE_W_LOG2 = 8,
   parameter int ZONE_H      = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pix_valid,
   input  logic              pix_sof,
   input  logic [3:0]        pix_r,
   input  logic [3:0]        pix_g,
   input  logic [3:0]        pix_b,
   output logic [7:0][20:0]  SumR,
   output logic [7:0][20:0]  SumG,
   output logic [7:0][20:0]  SumB,
   output logic              start_o,
   output logic              busy,
   output logic              frame_err
);

   localparam int COL_W = ZONE_W_LOG2 + 3;
   localparam int ROW_W = (ZONE_H > 1) ? $clog2(ZONE_H) : 1;
   localparam logic [COL_W-1:0] C_COL_LAST = '1;
   localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(ZONE_H - 1);

   typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [COL_W-1:0]    r_col;
   logic [ROW_W-1:0]    r_row;
   logic [7:0][20:0]    r_acc_r, r_acc_g, r_acc_b;
   logic [7:0][20:0]    w_nxt_r, w_nxt_g, w_nxt_b;
   logic [7:0][20:0]    r_sum_r, r_sum_g, r_sum_b;
   logic                r_start;
   logic                r_ferr;
   logic                w_sof;
   logic                w_add;
   logic                w_last;
   logic [2:0]          w_zone;

   function automatic logic [20:0] sat_add(input logic [20:0] a, input logic [3:0] p);
      logic [21:0] s;
      s = {1'b0, a} + {18'd0, p};
      return s[21] ? 21'h1FFFFF : s[20:0];
   endfunction

   assign w_sof  = pix_valid & pix_sof;
   assign w_add  = (r_state == S_ACC) & pix_valid & ~pix_sof;
   assign w_last = w_add & (r_col == C_COL_LAST) & (r_row == C_ROW_LAST);
   assign w_zone = r_col[COL_W-1 -: 3];

   // Only the zone under the current column takes the incoming pixel.
   for (genvar z = 0; z < 8; z++) begin : g_zone
      assign w_nxt_r[z] = (w_zone == 3'(z)) ? sat_add(r_acc_r[z], pix_r) : r_acc_r[z];
      assign w_nxt_g[z] = (w_zone == 3'(z)) ? sat_add(r_acc_g[z], pix_g) : r_acc_g[z];
      assign w_nxt_b[z] = (w_zone == 3'(z)) ? sat_add(r_acc_b[z], pix_b) : r_acc_b[z];
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_sof) begin
         w_state_nxt = S_ACC;
      end else if (w_last) begin
         w_state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_col   <= '0;
         r_row   <= '0;
         r_acc_r <= '0;
         r_acc_g <= '0;
         r_acc_b <= '0;
         r_sum_r <= '0;
         r_sum_g <= '0;
         r_sum_b <= '0;
         r_start <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_start <= 1'b0;
         r_ferr  <= 1'b0;
         if (w_sof) begin
            // sof always restarts: the pixel lands in zone 0 as col 0, row 0
            r_ferr     <= (r_state == S_ACC);
            r_acc_r    <= '0;
            r_acc_g    <= '0;
            r_acc_b    <= '0;
            r_acc_r[0] <= {17'd0, pix_r};
            r_acc_g[0] <= {17'd0, pix_g};
            r_acc_b[0] <= {17'd0, pix_b};
            r_col      <= COL_W'(1);
            r_row      <= '0;
         end else if (w_last) begin
            r_sum_r <= w_nxt_r;
            r_sum_g <= w_nxt_g;
            r_sum_b <= w_nxt_b;
            r_acc_r <= '0;
            r_acc_g <= '0;
            r_acc_b <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_start <= 1'b1;
         end else if (w_add) begin
            r_acc_r <= w_nxt_r;
            r_acc_g <= w_nxt_g;
            r_acc_b <= w_nxt_b;
            r_col   <= r_col + COL_W'(1);
            if (r_col == C_COL_LAST) begin
               r_row <= r_row + ROW_W'(1);
            end
         end
      end
   end

   assign SumR      = r_sum_r;
   assign SumG      = r_sum_g;
   assign SumB      = r_sum_b;
   assign start_o   = r_start;
   assign busy      = (r_state == S_ACC);
   assign frame_err = r_ferr;

endmodule

`default_nettype wire

// File: tb/tb_zone_sum_acc.sv
// ============================================================================
// Module   : tb_zone_sum_acc
// Purpose  : Directed self-checking bench for zone_sum_acc on a 32x2 frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zone_sum_acc;

   localparam int C_ZW_LOG2 = 2;
   localparam int C_ZH      = 2;
   localparam int C_LINE    = 8 << C_ZW_LOG2;
   localparam int C_NPIX    = C_LINE * C_ZH;

   logic             clk = 1'b0;
   logic             rst;
   logic             pix_valid;
   logic             pix_sof;
   logic [3:0]       pix_r, pix_g, pix_b;
   logic [7:0][20:0] SumR, SumG, SumB;
   logic             start_o;
   logic             busy;
   logic             frame_err;

   int n_vec  = 0;
   int n_err  = 0;
   int n_start = 0;
   int n_ferr  = 0;
   int n_busy  = 0;
   int s0, f0;

   zone_sum_acc #(.ZONE_W_LOG2(C_ZW_LOG2), .ZONE_H(C_ZH)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .pix_valid (pix_valid),
      .pix_sof   (pix_sof),
      .pix_r     (pix_r),
      .pix_g     (pix_g),
      .pix_b     (pix_b),
      .SumR      (SumR),
      .SumG      (SumG),
      .SumB      (SumB),
      .start_o   (start_o),
      .busy      (busy),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (start_o)   n_start++;
         if (frame_err) n_ferr++;
         if (busy)      n_busy++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic send_pixel(input bit sof, input int r, input int g, input int b);
      pix_valid = 1'b1;
      pix_sof   = sof;
      pix_r     = 4'(r);
      pix_g     = 4'(g);
      pix_b     = 4'(b);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      pix_valid = 1'b0;
      pix_sof   = 1'b1;
      pix_r     = 4'hF;
      pix_g     = 4'hF;
      pix_b     = 4'hF;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // mode 0: every channel = v; mode 1: R=zone, G=15-zone, B=1
   task automatic send_frame(input int mode, input int v, input int npix, input bit gaps);
      for (int p = 0; p < npix; p++) begin
         int zone;
         zone = (p % C_LINE) >> C_ZW_LOG2;
         if (gaps && p > 0) idle($urandom_range(0, 3));
         if (mode == 0) send_pixel(p == 0, v, v, v);
         else           send_pixel(p == 0, zone, 15 - zone, 1);
      end
   endtask

   task automatic check_uniform(input string tag, input int v);
      for (int z = 0; z < 8; z++) begin
         chk($sformatf("%s_R%0d", tag, z), 32'(SumR[z]), 32'(v));
         chk($sformatf("%s_G%0d", tag, z), 32'(SumG[z]), 32'(v));
         chk($sformatf("%s_B%0d", tag, z), 32'(SumB[z]), 32'(v));
      end
   endtask

   task automatic check_pattern(input string tag);
      for (int z = 0; z < 8; z++) begin
         chk($sformatf("%s_R%0d", tag, z), 32'(SumR[z]), 32'(8 * z));
         chk($sformatf("%s_G%0d", tag, z), 32'(SumG[z]), 32'(8 * (15 - z)));
         chk($sformatf("%s_B%0d", tag, z), 32'(SumB[z]), 32'd8);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      chk("rst_start", 32'(start_o), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      check_uniform("rst_sum", 0);

      // uniform 5, continuous
      send_frame(0, 5, C_NPIX, 1'b0);
      chk("t1_start_lat", 32'(start_o), 32'd1);
      chk("t1_busy_low", 32'(busy), 32'd0);
      chk("t1_busy_cycles", 32'(n_busy), 32'(C_NPIX - 1));
      check_uniform("t1_sum", 40);
      idle(1);
      chk("t1_start_1cyc", 32'(start_o), 32'd0);
      chk("t1_start_cnt", 32'(n_start), 32'd1);
      idle(4);
      check_uniform("t1_hold", 40);

      // zone pattern, continuous then gapped
      s0 = n_start;
      send_frame(1, 0, C_NPIX, 1'b0);
      idle(2);
      check_pattern("t2_cont");
      send_frame(1, 0, C_NPIX, 1'b1);
      idle(2);
      check_pattern("t2_gaps");
      chk("t2_start_cnt", 32'(n_start - s0), 32'd2);

      // pre-sof pixels ignored
      s0 = n_start;
      for (int i = 0; i < 10; i++) send_pixel(1'b0, 15, 15, 15);
      chk("t3_idle_busy", 32'(busy), 32'd0);
      send_frame(0, 1, C_NPIX, 1'b0);
      idle(2);
      check_uniform("t3_sum", 8);
      chk("t3_start_cnt", 32'(n_start - s0), 32'd1);

      // early sof abort
      s0 = n_start;
      f0 = n_ferr;
      send_frame(0, 3, 20, 1'b0);
      send_pixel(1'b1, 2, 2, 2);
      chk("t4_ferr_pulse", 32'(frame_err), 32'd1);
      chk("t4_busy_after_abort", 32'(busy), 32'd1);
      for (int p = 1; p < C_NPIX; p++) send_pixel(1'b0, 2, 2, 2);
      idle(2);
      chk("t4_ferr_cnt", 32'(n_ferr - f0), 32'd1);
      chk("t4_start_cnt", 32'(n_start - s0), 32'd1);
      check_uniform("t4_sum", 16);

      // back-to-back frames
      s0 = n_start;
      send_frame(0, 4, C_NPIX, 1'b0);
      chk("t5_start1", 32'(start_o), 32'd1);
      check_uniform("t5_sum1", 32);
      send_frame(0, 7, C_NPIX, 1'b0);
      chk("t5_start2", 32'(start_o), 32'd1);
      check_uniform("t5_sum2", 56);
      idle(2);
      chk("t5_start_cnt", 32'(n_start - s0), 32'd2);

      // reset mid-frame
      send_frame(0, 6, C_NPIX, 1'b0);
      idle(2);
      check_uniform("t6_pre", 48);
      s0 = n_start;
      send_frame(0, 6, 10, 1'b0);
      idle(0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check_uniform("t6_rst", 0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_start", 32'(start_o), 32'd0);
      idle(2);
      chk("t6_no_start", 32'(n_start - s0), 32'd0);
      send_frame(0, 9, C_NPIX, 1'b0);
      idle(2);
      check_uniform("t6_sum", 72);
      chk("t6_start_cnt", 32'(n_start - s0), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
